// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: sequences instruction fetch, squashes
// wrong-path words after a redirect, honours datapath stalls and halt.
module fetch_sequencer #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iStall,
    input  logic              iHalt,
    input  logic              iBranch_taken,
    input  logic              iJumpTaken,
    input  logic [ADDR_W-1:0] iBranch_dir,
    output logic [ADDR_W-1:0] oPC,
    output logic              oFetch_en,
    output logic              oFlush,
    output logic              oInstr_valid,
    output logic              oHalted,
    output logic [15:0]       oRedirect_cnt
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fetch_en_q, fetch_en_d;
    logic              flush_q, flush_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic [15:0]       redir_cnt_q, redir_cnt_d;
    logic [2:0]        flush_cnt_q, flush_cnt_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

    logic redir_live;
    assign redir_live = iJumpTaken | iBranch_taken;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_en_d  = fetch_en_q;
        flush_d     = flush_q;
        valid_d     = valid_q;
        halted_d    = halted_q;
        redir_cnt_d = redir_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pend_d      = pend_q;
        pend_tgt_d  = pend_tgt_q;

        unique case (state_q)
            BOOT: begin
                fetch_en_d = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                if (iStall) begin
                    fetch_en_d = 1'b0;
                    // Keep the first redirect seen while stalled.
                    if (redir_live && !pend_q) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = iBranch_dir;
                    end
                end else begin
                    fetch_en_d = 1'b1;
                    pend_d     = 1'b0;
                    if (pend_q || redir_live) begin
                        pc_d        = pend_q ? pend_tgt_q : iBranch_dir;
                        valid_d     = 1'b0;
                        flush_d     = 1'b1;
                        flush_cnt_d = 3'(FLUSH_CYCLES);
                        redir_cnt_d = (redir_cnt_q == 16'hFFFF) ? redir_cnt_q
                                                                : redir_cnt_q + 16'd1;
                        state_d     = FLUSH;
                    end else if (iHalt) begin
                        fetch_en_d = 1'b0;
                        valid_d    = 1'b0;
                        halted_d   = 1'b1;
                        state_d    = HALT;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        valid_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (iStall) begin
                    fetch_en_d = 1'b0;
                end else begin
                    fetch_en_d = 1'b1;
                    if (flush_cnt_q == 3'd1) begin
                        flush_d     = 1'b0;
                        valid_d     = 1'b1;
                        pc_d        = pc_q + 1'b1;
                        flush_cnt_d = '0;
                        state_d     = RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end
            end
            HALT: begin
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= BOOT;
            pc_q        <= ADDR_W'(RESET_VECTOR);
            fetch_en_q  <= 1'b0;
            flush_q     <= 1'b0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
            redir_cnt_q <= '0;
            flush_cnt_q <= '0;
            pend_q      <= 1'b0;
            pend_tgt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_en_q  <= fetch_en_d;
            flush_q     <= flush_d;
            valid_q     <= valid_d;
            halted_q    <= halted_d;
            redir_cnt_q <= redir_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            pend_q      <= pend_d;
            pend_tgt_q  <= pend_tgt_d;
        end
    end

    assign oPC           = pc_q;
    assign oFetch_en     = fetch_en_q;
    assign oFlush        = flush_q;
    assign oInstr_valid  = valid_q;
    assign oHalted       = halted_q;
    assign oRedirect_cnt = redir_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (reset vector 0 and 1022) driven with
// directed and random stimulus, compared every cycle against a behavioural model.
module tb_fetch_sequencer;

    localparam int AW = 10;
    localparam int FC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, stall, halt, br, jmp;
    logic [AW-1:0] dir;

    logic [AW-1:0] pc_a, pc_b;
    logic          fe_a, fe_b, fl_a, fl_b, v_a, v_b, h_a, h_b;
    logic [15:0]   cnt_a, cnt_b;

    fetch_sequencer #(.ADDR_W(AW), .RESET_VECTOR(0), .FLUSH_CYCLES(FC)) u_dut_a (
        .Clock(clk), .Reset(rst), .iStall(stall), .iHalt(halt),
        .iBranch_taken(br), .iJumpTaken(jmp), .iBranch_dir(dir),
        .oPC(pc_a), .oFetch_en(fe_a), .oFlush(fl_a), .oInstr_valid(v_a),
        .oHalted(h_a), .oRedirect_cnt(cnt_a)
    );

    fetch_sequencer #(.ADDR_W(AW), .RESET_VECTOR(1022), .FLUSH_CYCLES(FC)) u_dut_b (
        .Clock(clk), .Reset(rst), .iStall(stall), .iHalt(halt),
        .iBranch_taken(br), .iJumpTaken(jmp), .iBranch_dir(dir),
        .oPC(pc_b), .oFetch_en(fe_b), .oFlush(fl_b), .oInstr_valid(v_b),
        .oHalted(h_b), .oRedirect_cnt(cnt_b)
    );

    typedef struct {
        int pc;
        bit fe, fl, v, h;
        int cnt;
        bit booting;
        int flush_left;
        bit pend;
        int ptgt;
    } model_t;

    model_t m[2];
    int     rv[2] = '{0, 1022};

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of the reference behaviour, written from the observable rules.
    function automatic model_t step(input model_t s, input int rvec);
        model_t n = s;
        bit     redir;
        int     tgt;
        if (rst) begin
            n.pc = rvec; n.fe = 0; n.fl = 0; n.v = 0; n.h = 0; n.cnt = 0;
            n.booting = 1; n.flush_left = 0; n.pend = 0; n.ptgt = 0;
            return n;
        end
        if (s.h) return n;
        if (s.booting) begin
            n.booting = 0;
            n.fe = 1;
            return n;
        end
        if (stall) begin
            n.fe = 0;
            if (s.flush_left == 0 && (jmp || br) && !s.pend) begin
                n.pend = 1;
                n.ptgt = int'(dir);
            end
            return n;
        end
        n.fe = 1;
        if (s.flush_left > 0) begin
            n.flush_left = s.flush_left - 1;
            if (n.flush_left == 0) begin
                n.fl = 0;
                n.v  = 1;
                n.pc = (s.pc + 1) % (1 << AW);
            end
            return n;
        end
        redir  = s.pend || jmp || br;
        tgt    = s.pend ? s.ptgt : int'(dir);
        n.pend = 0;
        if (redir) begin
            n.pc = tgt; n.v = 0; n.fl = 1; n.flush_left = FC;
            if (s.cnt < 65535) n.cnt = s.cnt + 1;
        end else if (halt) begin
            n.fe = 0; n.v = 0; n.h = 1;
        end else begin
            n.pc = (s.pc + 1) % (1 << AW);
            n.v  = 1;
        end
        return n;
    endfunction

    task automatic check_dut(input int i, input logic [AW-1:0] p, input logic fe,
                             input logic fl, input logic v, input logic h,
                             input logic [15:0] c);
        check($sformatf("pc[%0d]", i),    32'(p),  32'(m[i].pc));
        check($sformatf("fetch[%0d]", i), 32'(fe), 32'(m[i].fe));
        check($sformatf("flush[%0d]", i), 32'(fl), 32'(m[i].fl));
        check($sformatf("valid[%0d]", i), 32'(v),  32'(m[i].v));
        check($sformatf("halt[%0d]", i),  32'(h),  32'(m[i].h));
        check($sformatf("rcnt[%0d]", i),  32'(c),  32'(m[i].cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) m[i] = step(m[i], rv[i]);
        #1;
        check_dut(0, pc_a, fe_a, fl_a, v_a, h_a, cnt_a);
        check_dut(1, pc_b, fe_b, fl_b, v_b, h_b, cnt_b);
    endtask

    task automatic drive(input logic r, input logic s, input logic hl, input logic b,
                         input logic j, input logic [AW-1:0] d);
        rst = r; stall = s; halt = hl; br = b; jmp = j; dir = d;
    endtask

    int exp_wrap[4] = '{1022, 1023, 0, 1};
    int exp_run[4]  = '{0, 1, 2, 3};

    initial begin
        drive(1, 0, 0, 0, 0, '0);
        tick();
        tick();
        check("rst_pc_a", 32'(pc_a), 32'd0);
        check("rst_pc_b", 32'(pc_b), 32'd1022);
        drive(0, 0, 0, 0, 0, '0);

        // Boot, then sequential fetch including the wrap on instance b.
        for (int k = 0; k < 4; k++) begin
            tick();
            check("seq_pc_a", 32'(pc_a), 32'(exp_run[k]));
            check("wrap_pc_b", 32'(pc_b), 32'(exp_wrap[k]));
            check("wrap_valid_b", 32'(v_b), (k == 0) ? 32'd0 : 32'd1);
        end

        for (int k = 0; k < 40 && m[0].pc != 'h10; k++) tick();
        check("reach_pc10", 32'(pc_a), 32'h10);
        drive(0, 0, 0, 0, 1, 10'h155);
        tick();
        drive(0, 0, 0, 0, 0, '0);
        check("jmp_pc", 32'(pc_a), 32'h155);
        check("jmp_flush1", 32'(fl_a), 32'd1);
        tick();
        check("jmp_flush2", 32'(fl_a), 32'd1);
        check("jmp_valid2", 32'(v_a), 32'd0);
        tick();
        check("jmp_after_pc", 32'(pc_a), 32'h156);
        check("jmp_after_valid", 32'(v_a), 32'd1);
        check("jmp_cnt", 32'(cnt_a), 32'd1);

        drive(0, 0, 0, 1, 1, 10'h07F);
        tick();
        check("dual_pc", 32'(pc_a), 32'h07F);
        check("dual_cnt", 32'(cnt_a), 32'd2);
        drive(0, 0, 0, 0, 1, 10'h200);
        tick();
        drive(0, 0, 0, 0, 0, '0);
        tick();
        check("flush_ignore_pc", 32'(pc_a), 32'h080);
        check("flush_ignore_cnt", 32'(cnt_a), 32'd2);

        drive(0, 1, 0, 1, 0, 10'h020);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_pc", 32'(pc_a), 32'h080);
            check("stall_fetch", 32'(fe_a), 32'd0);
        end
        drive(0, 0, 0, 0, 0, '0);
        tick();
        check("pend_pc", 32'(pc_a), 32'h020);
        check("pend_cnt", 32'(cnt_a), 32'd3);

        for (int k = 0; k < 40 && m[0].pc != 'h30; k++) tick();
        check("reach_pc30", 32'(pc_a), 32'h30);
        drive(0, 0, 1, 0, 0, '0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom));
            tick();
            check("halt_pc", 32'(pc_a), 32'h30);
            check("halt_flag", 32'(h_a), 32'd1);
        end
        drive(1, 0, 0, 0, 0, '0);
        tick();
        check("halt_rst_pc", 32'(pc_a), 32'd0);
        check("halt_rst_flag", 32'(h_a), 32'd0);

        drive(0, 0, 0, 0, 0, '0);
        tick();
        tick();
        drive(0, 0, 0, 0, 1, 10'h3FF);
        tick();
        drive(1, 0, 0, 0, 0, '0);
        tick();
        check("flush_rst_pc", 32'(pc_a), 32'd0);
        check("flush_rst_flush", 32'(fl_a), 32'd0);
        check("flush_rst_cnt", 32'(cnt_a), 32'd0);

        for (int k = 0; k < 3000; k++) begin
            drive(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 7) == 0), AW'($urandom));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
